// File: rtl/ex_stage_mc.sv
// Execute stage: operand forwarding, single-cycle ALU, branch resolve and iterative shift-add MUL.
// Define EX_STAGE_MC_DIV_EN to build the restoring DIVU/REMU unit; otherwise cmds 11/12 return 0.
module ex_stage_mc #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned N_FWD = 2,
  localparam int unsigned SW   = $clog2(N_FWD + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            exe_cmd,
  input  logic [XLEN-1:0]       val1,
  input  logic [XLEN-1:0]       val2,
  input  logic [XLEN-1:0]       val_src2,
  input  logic [XLEN-1:0]       pc_in,
  input  logic [1:0]            br_type,
  input  logic                  wb_en,
  input  logic                  mem_w,
  input  logic                  mem_r,
  input  logic [4:0]            dest,
  input  logic [N_FWD*XLEN-1:0] fwd_data,
  input  logic [SW-1:0]         val1_sel,
  input  logic [SW-1:0]         val2_sel,
  input  logic [SW-1:0]         st_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       alu_result,
  output logic [XLEN-1:0]       br_addr,
  output logic [XLEN-1:0]       st_val,
  output logic [XLEN-1:0]       pc_out,
  output logic                  br_taken,
  output logic                  wb_en_out,
  output logic                  mem_w_out,
  output logic                  mem_r_out,
  output logic [4:0]            dest_out,
  output logic                  busy
);

  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [3:0] CMD_ADD  = 4'd0;
  localparam logic [3:0] CMD_SUB  = 4'd1;
  localparam logic [3:0] CMD_AND  = 4'd2;
  localparam logic [3:0] CMD_OR   = 4'd3;
  localparam logic [3:0] CMD_NOR  = 4'd4;
  localparam logic [3:0] CMD_XOR  = 4'd5;
  localparam logic [3:0] CMD_SLL  = 4'd6;
  localparam logic [3:0] CMD_SRL  = 4'd7;
  localparam logic [3:0] CMD_SRA  = 4'd8;
  localparam logic [3:0] CMD_SLT  = 4'd9;
  localparam logic [3:0] CMD_MUL  = 4'd10;
`ifdef EX_STAGE_MC_DIV_EN
  localparam logic [3:0] CMD_DIVU = 4'd11;
  localparam logic [3:0] CMD_REMU = 4'd12;
`endif

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_BEQ  = 2'd1;
  localparam logic [1:0] BR_BNE  = 2'd2;
  localparam logic [1:0] BR_JMP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL
`ifdef EX_STAGE_MC_DIV_EN
    , S_DIV
`endif
  } state_t;

  state_t          state, state_n;
  logic [SHW-1:0]  cnt;
  logic [XLEN-1:0] op_a, op_b, op_c;
  logic [XLEN-1:0] p_br_addr, p_st_val, p_pc;
  logic            p_br_taken, p_wb_en, p_mem_w, p_mem_r;
  logic [4:0]      p_dest;

  logic            accept, is_mul, last_c, ld_single, ld_multi, iter;
  logic [XLEN-1:0] v1_c, v2_c, st_c, alu_c, br_addr_c, mul_acc_c, multi_c;
  logic            br_taken_c;
`ifdef EX_STAGE_MC_DIV_EN
  logic            is_div, is_rem, div_ge_c;
  logic [XLEN:0]   div_sh_c;
  logic [XLEN-1:0] div_rem_c, div_q_c;
`endif

  // Select 0 or an out-of-range select keeps the instruction's own operand.
  function automatic logic [XLEN-1:0] fwd_mux(input logic [SW-1:0] sel, input logic [XLEN-1:0] own);
    logic [XLEN-1:0] r;
    r = own;
    for (int k = 0; k < int'(N_FWD); k++)
      if (int'(sel) == k + 1) r = fwd_data[k*XLEN +: XLEN];
    return r;
  endfunction

  assign v1_c      = fwd_mux(val1_sel, val1);
  assign v2_c      = fwd_mux(val2_sel, val2);
  assign st_c      = fwd_mux(st_sel, val_src2);
  assign br_addr_c = pc_in + val2;

  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign is_mul   = (exe_cmd == CMD_MUL);
  assign last_c   = (cnt == SHW'(XLEN - 1));
`ifdef EX_STAGE_MC_DIV_EN
  assign is_div   = (exe_cmd == CMD_DIVU) || (exe_cmd == CMD_REMU);
`endif

  // Single-cycle ALU
  always_comb begin
    alu_c = '0;
    case (exe_cmd)
      CMD_ADD: alu_c = v1_c + v2_c;
      CMD_SUB: alu_c = v1_c - v2_c;
      CMD_AND: alu_c = v1_c & v2_c;
      CMD_OR:  alu_c = v1_c | v2_c;
      CMD_NOR: alu_c = ~(v1_c | v2_c);
      CMD_XOR: alu_c = v1_c ^ v2_c;
      CMD_SLL: alu_c = v1_c << v2_c[SHW-1:0];
      CMD_SRL: alu_c = v1_c >> v2_c[SHW-1:0];
      CMD_SRA: alu_c = XLEN'($signed(v1_c) >>> v2_c[SHW-1:0]);
      CMD_SLT: alu_c = XLEN'($signed(v1_c) < $signed(v2_c));
      default: alu_c = '0;
    endcase
  end

  always_comb begin
    br_taken_c = 1'b0;
    case (br_type)
      BR_NONE: br_taken_c = 1'b0;
      BR_BEQ:  br_taken_c = (v1_c == st_c);
      BR_BNE:  br_taken_c = (v1_c != st_c);
      BR_JMP:  br_taken_c = 1'b1;
      default: br_taken_c = 1'b0;
    endcase
  end

  // One iteration step; op_a = accumulator/remainder, op_b = multiplicand/quotient, op_c = multiplier/divisor.
  assign mul_acc_c = op_a + (op_c[0] ? op_b : '0);
`ifdef EX_STAGE_MC_DIV_EN
  assign div_sh_c  = {op_a, op_b[XLEN-1]};
  assign div_ge_c  = (div_sh_c >= {1'b0, op_c});
  assign div_rem_c = div_ge_c ? XLEN'(div_sh_c - {1'b0, op_c}) : div_sh_c[XLEN-1:0];
  assign div_q_c   = {op_b[XLEN-2:0], div_ge_c};
  assign multi_c   = (state == S_MUL) ? mul_acc_c : (is_rem ? div_rem_c : div_q_c);
`else
  assign multi_c   = mul_acc_c;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != S_IDLE);
    end
  end

  // Next state and load/iterate strobes
  always_comb begin
    state_n   = state;
    ld_single = 1'b0;
    ld_multi  = 1'b0;
    iter      = 1'b0;
    if (state == S_IDLE) begin
      if (accept) begin
        if (is_mul) state_n = S_MUL;
`ifdef EX_STAGE_MC_DIV_EN
        else if (is_div) state_n = S_DIV;
`endif
        else ld_single = 1'b1;
      end
    end else if (!last_c) begin
      iter = 1'b1;
    end else if (!(out_valid && !out_ready)) begin
      ld_multi = 1'b1;
      state_n  = S_IDLE;
    end
    if (flush) begin
      state_n  = S_IDLE;
      ld_multi = 1'b0;
      iter     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_result <= '0;
      br_addr    <= '0;
      st_val     <= '0;
      pc_out     <= '0;
      br_taken   <= 1'b0;
      wb_en_out  <= 1'b0;
      mem_w_out  <= 1'b0;
      mem_r_out  <= 1'b0;
      dest_out   <= '0;
    end else begin
      if (flush)                      out_valid <= 1'b0;
      else if (ld_single || ld_multi) out_valid <= 1'b1;
      else if (out_ready)             out_valid <= 1'b0;

      if (ld_single) begin
        alu_result <= alu_c;
        br_addr    <= br_addr_c;
        st_val     <= st_c;
        pc_out     <= pc_in;
        br_taken   <= br_taken_c;
        wb_en_out  <= wb_en;
        mem_w_out  <= mem_w;
        mem_r_out  <= mem_r;
        dest_out   <= dest;
      end else if (ld_multi) begin
        alu_result <= multi_c;
        br_addr    <= p_br_addr;
        st_val     <= p_st_val;
        pc_out     <= p_pc;
        br_taken   <= p_br_taken;
        wb_en_out  <= p_wb_en;
        mem_w_out  <= p_mem_w;
        mem_r_out  <= p_mem_r;
        dest_out   <= p_dest;
      end
    end
  end

  // Operands and side-band fields are frozen at acceptance for the iterative units.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_c       <= '0;
      p_br_addr  <= '0;
      p_st_val   <= '0;
      p_pc       <= '0;
      p_br_taken <= 1'b0;
      p_wb_en    <= 1'b0;
      p_mem_w    <= 1'b0;
      p_mem_r    <= 1'b0;
      p_dest     <= '0;
`ifdef EX_STAGE_MC_DIV_EN
      is_rem     <= 1'b0;
`endif
    end else if (accept) begin
      cnt        <= '0;
      op_a       <= '0;
      op_b       <= v1_c;
      op_c       <= v2_c;
      p_br_addr  <= br_addr_c;
      p_st_val   <= st_c;
      p_pc       <= pc_in;
      p_br_taken <= br_taken_c;
      p_wb_en    <= wb_en;
      p_mem_w    <= mem_w;
      p_mem_r    <= mem_r;
      p_dest     <= dest;
`ifdef EX_STAGE_MC_DIV_EN
      is_rem     <= (exe_cmd == CMD_REMU);
`endif
    end else if (iter) begin
      cnt <= cnt + SHW'(1);
      if (state == S_MUL) begin
        op_a <= mul_acc_c;
        op_b <= op_b << 1;
        op_c <= op_c >> 1;
      end
`ifdef EX_STAGE_MC_DIV_EN
      else begin
        op_a <= div_rem_c;
        op_b <= div_q_c;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed self-checking bench for ex_stage_mc (XLEN=32, N_FWD=2).
module tb_ex_stage_mc;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned N_FWD = 2;
  localparam int unsigned SW    = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  flush = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [3:0]            exe_cmd = '0;
  logic [XLEN-1:0]       val1 = '0, val2 = '0, val_src2 = '0, pc_in = '0;
  logic [1:0]            br_type = '0;
  logic                  wb_en = 1'b0, mem_w = 1'b0, mem_r = 1'b0;
  logic [4:0]            dest = '0;
  logic [N_FWD*XLEN-1:0] fwd_data = '0;
  logic [SW-1:0]         val1_sel = '0, val2_sel = '0, st_sel = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [XLEN-1:0]       alu_result, br_addr, st_val, pc_out;
  logic                  br_taken, wb_en_out, mem_w_out, mem_r_out;
  logic [4:0]            dest_out;
  logic                  busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ex_stage_mc #(.XLEN(XLEN), .N_FWD(N_FWD)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .exe_cmd(exe_cmd), .val1(val1), .val2(val2), .val_src2(val_src2), .pc_in(pc_in),
    .br_type(br_type), .wb_en(wb_en), .mem_w(mem_w), .mem_r(mem_r), .dest(dest),
    .fwd_data(fwd_data), .val1_sel(val1_sel), .val2_sel(val2_sel), .st_sel(st_sel),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .br_addr(br_addr), .st_val(st_val), .pc_out(pc_out), .br_taken(br_taken),
    .wb_en_out(wb_en_out), .mem_w_out(mem_w_out), .mem_r_out(mem_r_out),
    .dest_out(dest_out), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b, input string tag);
    exe_cmd  = cmd;
    val1     = a;
    val2     = b;
    in_valid = 1'b1;
    #1;
    chk({tag, "_rdy"}, 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
  endtask

  // Issue, then count edges from acceptance until out_valid (bounded).
  task automatic run_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input string tag, input bit chg_fwd);
    int   lat;
    logic bad;
    issue(cmd, a, b, tag);
    if (chg_fwd) fwd_data = '1;
    lat = 1;
    bad = 1'b0;
    while (!out_valid && lat < 100) begin
      if (!busy || in_ready) bad = 1'b1;
      step();
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, 64'(alu_result), 64'(exp));
    if (exp_lat > 1) chk({tag, "_busy_rdy"}, 64'(bad), 64'(0));
    chk({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;

    repeat (3) step();
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_busy",  64'(busy), 64'(0));
    chk("rst_alu",   64'(alu_result), 64'(0));
    chk("rst_pc",    64'(pc_out), 64'(0));
    chk("rst_dest",  64'(dest_out), 64'(0));
    rst = 1'b0;
    step();
    chk("post_rst_rdy", 64'(in_ready), 64'(1));

    pc_in = 32'h100; dest = 5'd3; wb_en = 1'b1; mem_r = 1'b1; val_src2 = 32'h55;
    issue(4'd0, 32'd5, 32'd7, "add");
    chk("add_valid", 64'(out_valid), 64'(1));
    chk("add_res",   64'(alu_result), 64'(12));
    chk("add_braddr", 64'(br_addr), 64'(32'h107));
    chk("add_pc",    64'(pc_out), 64'(32'h100));
    chk("add_dest",  64'(dest_out), 64'(3));
    chk("add_ctl",   64'({wb_en_out, mem_w_out, mem_r_out, br_taken}), 64'(4'b1010));
    chk("add_st",    64'(st_val), 64'(32'h55));

    fwd_data = {32'd77, 32'd100};
    val1_sel = 2'd1; st_sel = 2'd2; br_type = 2'd2;
    issue(4'd1, 32'd555, 32'd1, "sub_fwd");
    chk("sub_fwd_res", 64'(alu_result), 64'(99));
    chk("sub_fwd_st",  64'(st_val), 64'(77));
    chk("bne_taken",   64'(br_taken), 64'(1));

    val1_sel = 2'd0; st_sel = 2'd0; br_type = 2'd0; val2_sel = 2'd2;
    issue(4'd0, 32'd1, 32'h10, "add_fwd2");
    chk("add_fwd2_res",   64'(alu_result), 64'(78));
    chk("braddr_raw_v2",  64'(br_addr), 64'(32'h110));

    val2_sel = 2'd0; br_type = 2'd1; val_src2 = 32'hF0F0;
    issue(4'd5, 32'hF0F0, 32'h0FF0, "xor");
    chk("xor_res",   64'(alu_result), 64'(32'hFF00));
    chk("beq_taken", 64'(br_taken), 64'(1));

    br_type = 2'd0; val2_sel = 2'd3;
    issue(4'd6, 32'd1, 32'h24, "sll_sel3");
    chk("sll_sel3_res", 64'(alu_result), 64'(16));
    chk("none_taken",   64'(br_taken), 64'(0));
    val2_sel = 2'd0;

    issue(4'd8, 32'h8000_0000, 32'd4, "sra");
    chk("sra_res", 64'(alu_result), 64'(32'hF800_0000));
    br_type = 2'd3;
    issue(4'd9, 32'hFFFF_FFFF, 32'd1, "slt");
    chk("slt_res",   64'(alu_result), 64'(1));
    chk("jmp_taken", 64'(br_taken), 64'(1));
    br_type = 2'd0;
    issue(4'd4, 32'hF0F0_F0F0, 32'h0F0F_0000, "nor");
    chk("nor_res", 64'(alu_result), 64'(32'h0000_0F0F));

    run_op(4'd10, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 33, "mul", 1'b0);
    chk("mul_rdy_after", 64'(in_ready), 64'(1));
    run_op(4'd13, 32'd9, 32'd9, 32'd0, 1, "undef13", 1'b0);

`ifdef EX_STAGE_MC_DIV_EN
    run_op(4'd11, 32'd7, 32'd0, 32'hFFFF_FFFF, 33, "divu0", 1'b0);
    run_op(4'd12, 32'd7, 32'd0, 32'd7, 33, "remu0", 1'b0);
    run_op(4'd11, 32'd100, 32'd7, 32'd14, 33, "divu", 1'b0);
    run_op(4'd12, 32'd100, 32'd7, 32'd2, 33, "remu", 1'b0);
`else
    run_op(4'd10, 32'd6, 32'd7, 32'd42, 33, "mul_pre", 1'b0);
    run_op(4'd11, 32'd7, 32'd0, 32'd0, 1, "divu_undef", 1'b0);
    run_op(4'd10, 32'd6, 32'd7, 32'd42, 33, "mul_pre2", 1'b0);
    run_op(4'd12, 32'd7, 32'd0, 32'd0, 1, "remu_undef", 1'b0);
`endif

    fwd_data = {32'd0, 32'd3}; val1_sel = 2'd1;
    run_op(4'd10, 32'd999, 32'd5, 32'd15, 33, "mul_capture", 1'b1);
    val1_sel = 2'd0;
    step();
    chk("drain_valid", 64'(out_valid), 64'(0));

    out_ready = 1'b0; pc_in = 32'h200;
    issue(4'd0, 32'd3, 32'd4, "hold");
    chk("hold_res0", 64'(alu_result), 64'(7));
    for (int i = 0; i < 3; i++) begin
      exe_cmd = 4'd0; val1 = 32'd1; val2 = 32'd1; pc_in = 32'h300; in_valid = 1'b1;
      #1;
      chk("hold_rdy", 64'(in_ready), 64'(0));
      step();
      chk("hold_res",   64'(alu_result), 64'(7));
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_pc",    64'(pc_out), 64'(32'h200));
    end
    out_ready = 1'b1;
    #1;
    chk("release_rdy", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    chk("release_res", 64'(alu_result), 64'(2));
    chk("release_pc",  64'(pc_out), 64'(32'h300));
    step();
    chk("release_drain", 64'(out_valid), 64'(0));

    issue(4'd10, 32'h0000_FFFF, 32'h0001_0001, "mul_flush");
    repeat (9) step();
    chk("flush_busy_before", 64'(busy), 64'(1));
    flush = 1'b1; in_valid = 1'b1; exe_cmd = 4'd0;
    #1;
    chk("flush_rdy", 64'(in_ready), 64'(0));
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_busy",  64'(busy), 64'(0));
    chk("flush_rdy_after", 64'(in_ready), 64'(1));
    chk("flush_valid", 64'(out_valid), 64'(0));
    seen = 1'b0;
    repeat (40) begin
      step();
      seen = seen | out_valid;
    end
    chk("flush_no_result", 64'(seen), 64'(0));

    issue(4'd10, 32'd3, 32'd3, "mul_rst");
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk("rst_abort_busy", 64'(busy), 64'(0));
    step();
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      step();
      seen = seen | out_valid;
    end
    chk("rst_no_result", 64'(seen), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ex_stage_mc.md
EX_STAGE_MC -- requirements
Module: ex_stage_mc

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (8..64).
REQ-002 SHALL have parameter N_FWD, default 2, number of forwarding sources; SW = clog2(N_FWD+1).
REQ-003 SHALL have ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  kill in-flight and registered result.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- exe_cmd  in  4  ALU command.
- val1, val2, val_src2  in  XLEN  operand 1, operand 2, store data.
- pc_in  in  XLEN  PC of the instruction.
- br_type  in  2  0 none, 1 BEQ, 2 BNE, 3 JMP.
- wb_en, mem_w, mem_r  in  1  control passthrough.
- dest  in  5  destination register.
- fwd_data  in  N_FWD*XLEN  forwarding sources; source k at bits [k*XLEN +: XLEN].
- val1_sel, val2_sel, st_sel  in  SW  0 = own operand, k = fwd source k-1.
- out_valid  out  1  result register valid.
- out_ready  in  1  downstream accepts.
- alu_result, br_addr, st_val, pc_out  out  XLEN  registered results.
- br_taken, wb_en_out, mem_w_out, mem_r_out  out  1  registered.
- dest_out  out  5  registered.
- busy  out  1  multicycle op in progress.

Function
REQ-004 SHALL decode exe_cmd: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT signed, 10 MUL (low XLEN), 11 DIVU, 12 REMU; other codes yield result 0 in one cycle.
- Shift amount: low clog2(XLEN) bits of operand 2.
- Arithmetic: modulo 2^XLEN.
REQ-005 SHALL apply forwarding muxes to val1, val2 and val_src2 before the ALU and branch compare; sel > N_FWD selects own operand.
REQ-006 SHALL compute br_addr = pc_in + raw val2 (not forwarded), modulo 2^XLEN.
REQ-007 SHALL set br_taken: BEQ fwd val1 == fwd st value; BNE inequality; JMP 1; none 0.
REQ-008 SHALL implement FSM IDLE, MUL, DIV:
- IDLE -> MUL on accepted cmd 10.
- IDLE -> DIV on accepted cmd 11/12.
- MUL/DIV -> IDLE after XLEN iterations, loading the output register.
REQ-009 SHALL assert in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush.
REQ-010 SHALL load the output register for a single-cycle op on the accepting edge; out_valid rises 1 cycle after acceptance.
REQ-011 SHALL give MUL (shift-add) and DIV (restoring) latency of XLEN+1 cycles from acceptance to out_valid; busy is high in MUL/DIV.
REQ-012 SHALL wait in place in the final MUL/DIV iteration while out_valid && !out_ready.
REQ-013 SHALL keep all outputs stable while out_valid && !out_ready.
REQ-014 SHALL clear out_valid when out_ready is high and no new result loads.
REQ-015 SHALL produce, on divide by zero, quotient all-ones and remainder = dividend, with the same latency.
REQ-016 SHALL, on flush, clear out_valid and return to IDLE at the next edge; an in_valid offered in the same cycle is not accepted.
REQ-017 SHALL capture operands, including forwarded values, only at acceptance; later changes to fwd_data do not affect an in-flight op.

Reset
REQ-018 SHALL on rst:
- Set state IDLE.
- Clear out_valid and busy.
- Clear all result, control and pc_out registers to 0.
REQ-019 SHALL abort any MUL/DIV on rst; no result is produced after release.

Configuration
REQ-020 SHALL compile the iterative divider only when macro EX_STAGE_MC_DIV_EN is defined.
REQ-021 SHALL, without EX_STAGE_MC_DIV_EN, omit the DIV state and treat cmds 11/12 as undefined (result 0, one cycle).

Verification
REQ-022 SHALL cover ADD 5+7, XLEN=32, out_ready=1 -> next cycle alu_result=12, out_valid=1.
REQ-023 SHALL cover val1_sel=1, fwd source 0 = 100, SUB val2=1 -> alu_result=99.
REQ-024 SHALL cover MUL 0xFFFF x 0x10001 -> alu_result 0xFFFFFFFF after 33 cycles; in_ready=0 and busy=1 meanwhile.
REQ-025 SHALL cover DIVU 7/0 with the macro -> 0xFFFFFFFF, and REMU 7/0 -> 7; without the macro -> result 0 after 1 cycle.
REQ-026 SHALL cover out_ready=0 for 3 cycles with a result held -> outputs stable, in_ready=0; then out_ready=1 -> next op accepted.
REQ-027 SHALL cover flush at cycle 10 of a MUL -> out_valid never set, busy=0 and in_ready=1 next cycle.
